ro_race_ctrl: RTL

Sequencer for the ring-oscillator race used by the PUF response path. On a start request it latches a challenge, drives the RO-pair select, clears and then enables the two 8-bit race counters, and watches for the first counter to saturate. It then freezes the race and returns a response bit, a confidence margin and tie/timeout flags over a valid/ready handshake. It sits between the challenge source and the counter/comparator datapath, replacing free-running comparison with a bounded, repeatable measurement.

---
 rtl/ro_race_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/ro_race_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ro_race_ctrl
//  Purpose  : Sequencer for the ring-oscillator race of the PUF response
//             path. Latches a challenge, clears the two race counters for
//             SETTLE cycles, enables the oscillators and watches for the
//             first counter to saturate (bounded by TIMEOUT cycles). The
//             result is frozen and offered over a valid/ready handshake.
//  Ports    : clk, rst            - clock, asynchronous active-high reset
//             start, chal_in      - measurement request and its challenge
//             count1, count2      - race counters A and B (clk domain)
//             ro_sel              - RO-pair select (latched challenge)
//             cnt_clr, ro_en      - counter clear / oscillator enable
//             busy                - high whenever not idle
//             resp_valid/ready    - response handshake
//             resp_bit, resp_margin, resp_tie, resp_timeout - response
//  Revision : 1.0 - initial release
// ============================================================================
module ro_race_ctrl #(
  parameter int CHAL_W  = 4,
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CHAL_W-1:0] chal_in,
  input  logic [7:0]        count1,
  input  logic [7:0]        count2,
  output logic [CHAL_W-1:0] ro_sel,
  output logic              cnt_clr,
  output logic              ro_en,
  output logic              busy,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_bit,
  output logic [7:0]        resp_margin,
  output logic              resp_tie,
  output logic              resp_timeout
);

  localparam int CW = $clog2(TIMEOUT);
  localparam int SW = $clog2(SETTLE + 1);

  localparam logic [CW-1:0] C_CYC_LAST    = CW'(TIMEOUT - 1);
  localparam logic [SW-1:0] C_SETTLE_LAST = SW'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cyc;
  logic [SW-1:0]   r_settle;
  logic            w_sat1;
  logic            w_sat2;

  assign w_sat1 = &count1;
  assign w_sat2 = &count2;

  // All outputs are registered; every state transition updates the
  // outputs that the destination state requires on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cyc        <= '0;
      r_settle     <= '0;
      ro_sel       <= '0;
      cnt_clr      <= 1'b0;
      ro_en        <= 1'b0;
      busy         <= 1'b0;
      resp_valid   <= 1'b0;
      resp_bit     <= 1'b0;
      resp_margin  <= 8'd0;
      resp_tie     <= 1'b0;
      resp_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            ro_sel   <= chal_in;
            cnt_clr  <= 1'b1;
            busy     <= 1'b1;
            r_settle <= '0;
            r_state  <= S_CLEAR;
          end
        end

        S_CLEAR: begin
          // Clear is held for exactly SETTLE cycles before enabling.
          if (r_settle == C_SETTLE_LAST) begin
            cnt_clr <= 1'b0;
            ro_en   <= 1'b1;
            r_cyc   <= '0;
            r_state <= S_RUN;
          end else begin
            r_settle <= r_settle + SW'(1);
          end
        end

        S_RUN: begin
          // Saturation outranks timeout, including on the last cycle.
          if (w_sat1 || w_sat2 || (r_cyc == C_CYC_LAST)) begin
            ro_en        <= 1'b0;
            resp_valid   <= 1'b1;
            resp_tie     <= 1'b0;
            resp_timeout <= 1'b0;
            resp_bit     <= 1'b0;
            resp_margin  <= 8'd0;
            r_state      <= S_HOLD;
            if (w_sat1 && w_sat2) begin
              resp_tie <= 1'b1;
            end else if (w_sat1) begin
              resp_bit    <= 1'b1;
              resp_margin <= ~count2;
            end else if (w_sat2) begin
              resp_margin <= ~count1;
            end else begin
              resp_timeout <= 1'b1;
            end
          end else begin
            r_cyc <= r_cyc + CW'(1);
          end
        end

        S_HOLD: begin
          // resp_* fields are left untouched so they persist after transfer.
          if (resp_ready) begin
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            r_state    <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
